fdiv_issue: RTL



---
 rtl/fdiv_issue_pkg.sv | 14 +
 rtl/fdiv_issue_if.sv | 49 ++++
 rtl/fdiv_issue_req_fifo.sv | 57 +++++
 rtl/fdiv_issue.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fdiv_issue_pkg.sv
// Shared FP-unit definitions for the fdiv issue/writeback front end.
//   FP_W    : IEEE single operand/result width
//   state_e : issue FSM state (idle, divider running, result held for writeback)
package fdiv_issue_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

endpackage

// File: rtl/fdiv_issue_if.sv
// Bus bundle between the FP decode stage, the fdiv core and the register-file writeback port.
//   req_* : request channel from decode (valid/ready)
//   div_* : launch/result signals to and from the fdiv core
//   wb_*  : writeback channel to the register file (valid/ready)
// Modport slave is the issue unit's view; master is the view of everything around it.
interface fdiv_issue_if
    import fdiv_issue_pkg::*;
#(
    parameter int unsigned TAG_W = 6
) ();

    logic             req_valid;
    logic             req_ready;
    logic [FP_W-1:0]  req_x1;
    logic [FP_W-1:0]  req_x2;
    logic [TAG_W-1:0] req_tag;

    logic             div_start;
    logic [FP_W-1:0]  div_x1;
    logic [FP_W-1:0]  div_x2;
    logic [FP_W-1:0]  div_y;
    logic             div_ovf;
    logic             div_valid;

    logic             wb_valid;
    logic             wb_ready;
    logic [FP_W-1:0]  wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_ovf;

    modport slave (
        input  req_valid, req_x1, req_x2, req_tag,
        output req_ready,
        output div_start, div_x1, div_x2,
        input  div_y, div_ovf, div_valid,
        output wb_valid, wb_data, wb_tag, wb_ovf,
        input  wb_ready
    );

    modport master (
        output req_valid, req_x1, req_x2, req_tag,
        input  req_ready,
        input  div_start, div_x1, div_x2,
        output div_y, div_ovf, div_valid,
        input  wb_valid, wb_data, wb_tag, wb_ovf,
        output wb_ready
    );

endinterface

// File: rtl/fdiv_issue_req_fifo.sv
// fdiv_req_fifo: small synchronous request FIFO.
//   clk, rstn    : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  : write strobe and data; ignored while full
//   pop          : read strobe; ignored while empty
//   rdata        : current head entry (valid when !empty)
//   full, empty  : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap by plain overflow.
module fdiv_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fdiv_issue.sv
// fdiv_issue: issue/writeback front end for the multi-cycle FP divider.
//   clk, rstn  : clock, asynchronous active-low reset (drops queued and in-flight work)
//   bus        : request, divider and writeback channels (fdiv_issue_if.slave)
//   ovf_sticky : accumulated overflow for the FP status register
//   ovf_clr    : clears ovf_sticky (a simultaneous overflow capture wins)
//   busy       : requests queued or a divide/writeback in progress
// Only one divide is ever outstanding, so results return in request order.
module fdiv_issue
    import fdiv_issue_pkg::*;
#(
    parameter int unsigned TAG_W = 6,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    fdiv_issue_if.slave  bus,
    output logic         ovf_sticky,
    input  logic         ovf_clr,
    output logic         busy
);

    localparam int unsigned REQ_W = 2 * FP_W + TAG_W;

    state_e state_q, state_d;

    logic             start_q, start_d;
    logic [FP_W-1:0]  x1_q, x1_d, x2_q, x2_d;
    logic [TAG_W-1:0] itag_q, itag_d;
    logic             wb_valid_q, wb_valid_d;
    logic [FP_W-1:0]  wb_data_q, wb_data_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic             wb_ovf_q, wb_ovf_d;
    logic             sticky_q, sticky_d;

    logic [REQ_W-1:0] head;
    logic [FP_W-1:0]  head_x1, head_x2;
    logic [TAG_W-1:0] head_tag;
    logic             fifo_full, fifo_empty;
    logic             launch, capture;

    fdiv_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.req_valid),
        .wdata ({bus.req_x1, bus.req_x2, bus.req_tag}),
        .pop   (launch),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_x1, head_x2, head_tag} = head;

    // A new divide may only start once the previous result has left the unit;
    // restarting fdiv while it runs would silently discard the pending result.
    assign launch  = !fifo_empty &&
                     ((state_q == StIdle) || ((state_q == StHold) && bus.wb_ready));
    // Stale valids from an fdiv that kept running across a reset are ignored.
    assign capture = (state_q == StRun) && bus.div_valid;

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        x1_d       = x1_q;
        x2_d       = x2_q;
        itag_d     = itag_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_tag_d   = wb_tag_q;
        wb_ovf_d   = wb_ovf_q;
        sticky_d   = sticky_q;

        unique case (state_q)
            StIdle: begin
                if (launch) state_d = StRun;
            end
            StRun: begin
                if (capture) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = bus.div_y;
                    wb_ovf_d   = bus.div_ovf;
                    wb_tag_d   = itag_q;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (bus.wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = launch ? StRun : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            start_d = 1'b1;
            x1_d    = head_x1;
            x2_d    = head_x2;
            itag_d  = head_tag;
        end

        if (ovf_clr) sticky_d = 1'b0;
        if (capture && bus.div_ovf) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            x1_q       <= '0;
            x2_q       <= '0;
            itag_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
            wb_ovf_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            itag_q     <= itag_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_tag_q   <= wb_tag_d;
            wb_ovf_q   <= wb_ovf_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.div_start = start_q;
    assign bus.div_x1    = x1_q;
    assign bus.div_x2    = x2_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_tag    = wb_tag_q;
    assign bus.wb_ovf    = wb_ovf_q;
    assign ovf_sticky    = sticky_q;
    assign busy          = !fifo_empty || (state_q != StIdle);

endmodule
